// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: IEEE-754 add/subtract with generic format and 1..4 register pipeline.
// Steps (align, add, normalize, round) are folded into STAGES register slices.
module fp_addsub_pipe #(
   parameter int EXP_W  = 8,
   parameter int MAN_W  = 23,
   parameter int STAGES = 3,
   parameter int TAG_W  = 7
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic [STAGES-1:0]       clear,
   input  logic                    in_valid,
   input  logic                    op_sub,
   input  logic [EXP_W+MAN_W:0]    a,
   input  logic [EXP_W+MAN_W:0]    b,
   input  logic [2:0]              rm,
   input  logic [TAG_W-1:0]        tag_i,
   output logic                    out_valid,
   output logic [EXP_W+MAN_W:0]    result,
   output logic [4:0]              fflags,
   output logic [TAG_W-1:0]        tag_o,
   output logic [STAGES-1:0]       stage_valid,
   output logic [STAGES*TAG_W-1:0] stage_tag
);
   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int MW = MAN_W + 4;
   localparam int EW = EXP_W + 1;
   localparam logic [EXP_W-1:0] EMAX = '1;
   localparam logic [EXP_W-1:0] EBIG = EMAX - 1'b1;
   localparam logic [W-1:0] QNAN = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};
   localparam logic [2:0] RTZ = 3'b001;
   localparam logic [2:0] RDN = 3'b010;
   localparam logic [2:0] RUP = 3'b011;
   localparam logic [2:0] RMM = 3'b100;

   typedef struct packed {
      logic [W-1:0]       a;
      logic [W-1:0]       b;
      logic               op_sub;
      logic [2:0]         rm;
      logic [TAG_W-1:0]   tag;
      logic               special;
      logic               nv;
      logic [W-1:0]       spec_val;
      logic               sl;
      logic               eff_sub;
      logic [EW-1:0]      el;
      logic [MW-1:0]      ml;
      logic [MW-1:0]      ms;
      logic [MW:0]        sum;
      logic               sign;
      logic [MW-1:0]      nm;
      logic [EW-1:0]      ne;
      logic [W-1:0]       res;
      logic [4:0]         flags;
   } pipe_t;

   function automatic pipe_t step_align(pipe_t p);
      logic sa, sb, swap, a_nan, b_nan, a_inf, b_inf, bad;
      logic [EXP_W-1:0] ea, eb, el, es, diff;
      logic [MW-1:0] ma, mb, ml, mn, lost;
      sa = p.a[W-1];
      sb = p.b[W-1] ^ p.op_sub;
      a_nan = p.a[W-2:MAN_W] == EMAX && p.a[MAN_W-1:0] != '0;
      b_nan = p.b[W-2:MAN_W] == EMAX && p.b[MAN_W-1:0] != '0;
      a_inf = p.a[W-2:MAN_W] == EMAX && p.a[MAN_W-1:0] == '0;
      b_inf = p.b[W-2:MAN_W] == EMAX && p.b[MAN_W-1:0] == '0;
      bad = a_nan | b_nan | (a_inf & b_inf & (sa ^ sb));
      p.special = a_nan | b_nan | a_inf | b_inf;
      p.nv = (a_nan & ~p.a[MAN_W-1]) | (b_nan & ~p.b[MAN_W-1]) | (a_inf & b_inf & (sa ^ sb));
      p.spec_val = bad ? QNAN : a_inf ? {sa, EMAX, {MAN_W{1'b0}}} : {sb, EMAX, {MAN_W{1'b0}}};
      // subnormals carry a hidden 0 and behave as exponent 1
      ma = {p.a[W-2:MAN_W] != '0, p.a[MAN_W-1:0], 3'b000};
      mb = {p.b[W-2:MAN_W] != '0, p.b[MAN_W-1:0], 3'b000};
      ea = p.a[W-2:MAN_W] == '0 ? EXP_W'(1) : p.a[W-2:MAN_W];
      eb = p.b[W-2:MAN_W] == '0 ? EXP_W'(1) : p.b[W-2:MAN_W];
      swap = p.b[W-2:0] > p.a[W-2:0];
      el = swap ? eb : ea;
      es = swap ? ea : eb;
      ml = swap ? mb : ma;
      mn = swap ? ma : mb;
      diff = el - es;
      lost = mn & ~({MW{1'b1}} << diff);
      p.ms = int'(diff) >= MW - 1 ? {{(MW-1){1'b0}}, |mn} : (mn >> diff) | {{(MW-1){1'b0}}, |lost};
      p.ml = ml;
      p.el = {1'b0, el};
      p.sl = swap ? sb : sa;
      p.eff_sub = sa ^ sb;
      return p;
   endfunction

   function automatic pipe_t step_add(pipe_t p);
      p.sum = p.eff_sub ? {1'b0, p.ml} - {1'b0, p.ms} : {1'b0, p.ml} + {1'b0, p.ms};
      p.sign = (p.sum == '0 && p.eff_sub) ? (p.rm == RDN) : p.sl;
      return p;
   endfunction

   function automatic pipe_t step_norm(pipe_t p);
      int lz, sh;
      lz = MW;
      for (int i = 0; i < MW; i++)
         if (p.sum[i]) lz = MW - 1 - i;
      // left shift stops at exponent 1 so tiny results land as subnormals
      sh = lz < int'(p.el) - 1 ? lz : int'(p.el) - 1;
      p.nm = p.sum[MW] ? (p.sum[MW:1] | MW'(p.sum[0])) : p.sum[MW-1:0] << sh;
      p.ne = p.sum[MW] ? p.el + 1'b1 : p.el - EW'(sh);
      return p;
   endfunction

   function automatic pipe_t step_round(pipe_t p);
      logic g, inx, up, of, to_inf;
      logic [MAN_W+1:0] mant;
      logic [EW-1:0] ef;
      logic [MAN_W-1:0] fr;
      g = p.nm[2];
      inx = |p.nm[2:0];
      up = p.rm == RTZ ? 1'b0 : p.rm == RDN ? inx & p.sign : p.rm == RUP ? inx & ~p.sign :
           p.rm == RMM ? g : g & (p.nm[1] | p.nm[0] | p.nm[3]);
      mant = {1'b0, p.nm[MW-1:3]} + {{(MAN_W+1){1'b0}}, up};
      ef = mant[MAN_W+1] ? p.ne + 1'b1 : mant[MAN_W] ? p.ne : '0;
      fr = mant[MAN_W+1] ? mant[MAN_W:1] : mant[MAN_W-1:0];
      of = ef >= {1'b0, EMAX};
      to_inf = p.rm == RTZ ? 1'b0 : p.rm == RDN ? p.sign : p.rm == RUP ? ~p.sign : 1'b1;
      p.res = p.special ? p.spec_val : !of ? {p.sign, ef[EXP_W-1:0], fr} :
              to_inf ? {p.sign, EMAX, {MAN_W{1'b0}}} : {p.sign, EBIG, {MAN_W{1'b1}}};
      p.flags = p.special ? {p.nv, 4'b0000} : {2'b00, of, ef == '0 && inx, inx | of};
      return p;
   endfunction

   function automatic pipe_t run(pipe_t p, int first, int last);
      pipe_t x;
      x = p;
      for (int s = 1; s <= 4; s++)
         if (s >= first && s <= last)
            x = s == 1 ? step_align(x) : s == 2 ? step_add(x) : s == 3 ? step_norm(x) : step_round(x);
      return x;
   endfunction

   function automatic int first_step(int k);
      return STAGES >= 4 ? k + 1 : STAGES == 3 ? (k == 0 ? 1 : k + 2) : STAGES == 2 ? 2 * k + 1 : 1;
   endfunction

   function automatic int last_step(int k);
      return STAGES >= 4 ? k + 1 : STAGES == 3 ? k + 2 : STAGES == 2 ? 2 * k + 2 : 4;
   endfunction

   logic             vld [STAGES];
   logic [TAG_W-1:0] tg  [STAGES];
   pipe_t            q   [STAGES];

   for (genvar k = 0; k < STAGES; k++) begin : g_st
      localparam int F = first_step(k);
      localparam int L = last_step(k);
      pipe_t up, d;
      logic v_up;
      logic [TAG_W-1:0] t_up;
      if (k == 0) begin : g_first
         always_comb begin
            up = '0;
            up.a = a;
            up.b = b;
            up.op_sub = op_sub;
            up.rm = rm;
            up.tag = tag_i;
         end
         assign v_up = in_valid;
         assign t_up = tag_i;
      end else begin : g_next
         assign up = q[k-1];
         assign v_up = vld[k-1];
         assign t_up = tg[k-1];
      end
      assign d = run(up, F, L);
      // datapath only loads real ops so the output side holds across bubbles
      always_ff @(posedge clk or negedge rst)
         if (!rst) begin
            vld[k] <= 1'b0;
            tg[k] <= '0;
            q[k] <= '0;
         end else if (clear[k]) begin
            vld[k] <= 1'b0;
            tg[k] <= '0;
         end else if (en) begin
            vld[k] <= v_up;
            tg[k] <= t_up;
            if (v_up) q[k] <= d;
         end
      assign stage_valid[k] = vld[k];
      assign stage_tag[k*TAG_W +: TAG_W] = tg[k];
   end

   assign out_valid = vld[STAGES-1];
   assign result = q[STAGES-1].res;
   assign fflags = q[STAGES-1].flags;
   assign tag_o = q[STAGES-1].tag;
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// tb_fp_addsub_pipe: directed checks of fp_addsub_pipe (binary32, 3 stages).
module tb_fp_addsub_pipe;
   localparam int STAGES = 3;
   localparam int TAG_W  = 7;

   typedef struct {
      logic [31:0] x;
      logic [31:0] y;
      logic        sub;
      logic [2:0]  mode;
      logic [31:0] res;
      logic [4:0]  flg;
   } vec_t;

   logic clk = 1'b0, rst = 1'b0, en = 1'b0, in_valid = 1'b0, op_sub = 1'b0;
   logic [STAGES-1:0] clear = '0;
   logic [31:0] a = '0, b = '0;
   logic [2:0] rm = '0;
   logic [TAG_W-1:0] tag_i = '0;
   logic out_valid;
   logic [31:0] result;
   logic [4:0] fflags;
   logic [TAG_W-1:0] tag_o;
   logic [STAGES-1:0] stage_valid;
   logic [STAGES*TAG_W-1:0] stage_tag;
   int checks = 0, failures = 0;
   logic [31:0] r_res;
   logic [4:0] r_flg;
   logic [TAG_W-1:0] r_tag;
   int r_lat;

   fp_addsub_pipe #(.EXP_W(8), .MAN_W(23), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst), .en(en), .clear(clear), .in_valid(in_valid), .op_sub(op_sub),
      .a(a), .b(b), .rm(rm), .tag_i(tag_i), .out_valid(out_valid), .result(result),
      .fflags(fflags), .tag_o(tag_o), .stage_valid(stage_valid), .stage_tag(stage_tag)
   );

   always #5 clk = ~clk;

   task automatic exec(input logic [31:0] x, input logic [31:0] y, input logic sub,
                       input logic [2:0] mode, input logic [TAG_W-1:0] t);
      @(negedge clk);
      a = x; b = y; op_sub = sub; rm = mode; tag_i = t; in_valid = 1'b1; en = 1'b1; clear = '0;
      @(negedge clk);
      in_valid = 1'b0;
      r_lat = 1;
      while (!out_valid && r_lat < 20) begin
         @(negedge clk);
         r_lat++;
      end
      r_res = result; r_flg = fflags; r_tag = tag_o;
   endtask

   task automatic test_reset();
      en = 1'b1; in_valid = 1'b1; tag_i = 7'h55; a = 32'h3F800000; b = 32'h3F800000;
      repeat (3) @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset out_valid got=%b exp=0", out_valid); end
      checks++; if (result !== 32'h0) begin failures++; $display("FAIL reset result got=%h exp=00000000", result); end
      checks++; if (fflags !== 5'h0 || tag_o !== '0) begin failures++; $display("FAIL reset flags/tag got=%h/%h exp=0/0", fflags, tag_o); end
      checks++; if (stage_valid !== '0 || stage_tag !== '0) begin failures++; $display("FAIL reset stages got=%b/%h exp=0/0", stage_valid, stage_tag); end
      in_valid = 1'b0;
      rst = 1'b1;
   endtask

   task automatic test_basic();
      exec(32'h3F800000, 32'h40000000, 1'b0, 3'b000, 7'h2A);
      checks++; if (r_lat !== STAGES) begin failures++; $display("FAIL basic latency got=%0d exp=%0d", r_lat, STAGES); end
      checks++; if (r_res !== 32'h40400000) begin failures++; $display("FAIL basic result got=%h exp=40400000", r_res); end
      checks++; if (r_flg !== 5'h0) begin failures++; $display("FAIL basic fflags got=%h exp=00", r_flg); end
      checks++; if (r_tag !== 7'h2A) begin failures++; $display("FAIL basic tag got=%h exp=2a", r_tag); end
      repeat (2) @(negedge clk);
      checks++; if (out_valid !== 1'b0 || result !== 32'h40400000 || tag_o !== 7'h2A)
         begin failures++; $display("FAIL basic hold got=%b/%h/%h exp=0/40400000/2a", out_valid, result, tag_o); end
   endtask

   task automatic test_zeros();
      vec_t v [4] = '{
         '{32'h3F800000, 32'h3F800000, 1'b1, 3'b000, 32'h00000000, 5'h00},
         '{32'h3F800000, 32'h3F800000, 1'b1, 3'b010, 32'h80000000, 5'h00},
         '{32'h80000000, 32'h80000000, 1'b0, 3'b000, 32'h80000000, 5'h00},
         '{32'h00000000, 32'h00000000, 1'b0, 3'b011, 32'h00000000, 5'h00}};
      for (int i = 0; i < 4; i++) begin
         exec(v[i].x, v[i].y, v[i].sub, v[i].mode, TAG_W'(i));
         checks++; if (r_res !== v[i].res || r_flg !== v[i].flg)
            begin failures++; $display("FAIL zeros[%0d] got=%h/%h exp=%h/%h", i, r_res, r_flg, v[i].res, v[i].flg); end
      end
   endtask

   task automatic test_specials();
      vec_t v [5] = '{
         '{32'h7F800000, 32'hFF800000, 1'b0, 3'b000, 32'h7FC00000, 5'h10},
         '{32'h7F800000, 32'h7F800000, 1'b1, 3'b000, 32'h7FC00000, 5'h10},
         '{32'h7F800001, 32'h3F800000, 1'b0, 3'b000, 32'h7FC00000, 5'h10},
         '{32'h7FC00000, 32'h3F800000, 1'b0, 3'b000, 32'h7FC00000, 5'h00},
         '{32'hFF800000, 32'h3F800000, 1'b0, 3'b000, 32'hFF800000, 5'h00}};
      for (int i = 0; i < 5; i++) begin
         exec(v[i].x, v[i].y, v[i].sub, v[i].mode, TAG_W'(i));
         checks++; if (r_res !== v[i].res || r_flg !== v[i].flg)
            begin failures++; $display("FAIL special[%0d] got=%h/%h exp=%h/%h", i, r_res, r_flg, v[i].res, v[i].flg); end
      end
   endtask

   task automatic test_overflow();
      vec_t v [4] = '{
         '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 3'b000, 32'h7F800000, 5'h05},
         '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 3'b001, 32'h7F7FFFFF, 5'h05},
         '{32'hFF7FFFFF, 32'h7F7FFFFF, 1'b1, 3'b011, 32'hFF7FFFFF, 5'h05},
         '{32'hFF7FFFFF, 32'h7F7FFFFF, 1'b1, 3'b010, 32'hFF800000, 5'h05}};
      for (int i = 0; i < 4; i++) begin
         exec(v[i].x, v[i].y, v[i].sub, v[i].mode, TAG_W'(i));
         checks++; if (r_res !== v[i].res || r_flg !== v[i].flg)
            begin failures++; $display("FAIL overflow[%0d] got=%h/%h exp=%h/%h", i, r_res, r_flg, v[i].res, v[i].flg); end
      end
   endtask

   task automatic test_rounding();
      vec_t v [8] = '{
         '{32'h3F800000, 32'h30800000, 1'b0, 3'b000, 32'h3F800000, 5'h01},
         '{32'h3F800000, 32'h30800000, 1'b0, 3'b011, 32'h3F800001, 5'h01},
         '{32'h3F800000, 32'h33800000, 1'b0, 3'b000, 32'h3F800000, 5'h01},
         '{32'h3F800000, 32'h33800000, 1'b0, 3'b100, 32'h3F800001, 5'h01},
         '{32'h00000001, 32'h00000001, 1'b0, 3'b000, 32'h00000002, 5'h00},
         '{32'h00800001, 32'h00800000, 1'b1, 3'b000, 32'h00000001, 5'h00},
         '{32'h40400000, 32'h3F800000, 1'b1, 3'b000, 32'h40000000, 5'h00},
         '{32'hBF800000, 32'h3F000000, 1'b0, 3'b111, 32'hBF000000, 5'h00}};
      for (int i = 0; i < 8; i++) begin
         exec(v[i].x, v[i].y, v[i].sub, v[i].mode, TAG_W'(i));
         checks++; if (r_res !== v[i].res || r_flg !== v[i].flg)
            begin failures++; $display("FAIL round[%0d] got=%h/%h exp=%h/%h", i, r_res, r_flg, v[i].res, v[i].flg); end
      end
   endtask

   task automatic test_back_to_back();
      logic [STAGES*TAG_W-1:0] snap;
      @(negedge clk);
      en = 1'b1; clear = '0; a = 32'h3F800000; b = 32'h40000000; op_sub = 1'b0; rm = 3'b000;
      in_valid = 1'b1; tag_i = 7'd1;
      @(negedge clk); tag_i = 7'd2;
      @(negedge clk); tag_i = 7'd3;
      @(negedge clk);
      checks++; if (stage_valid !== 3'b111 || stage_tag !== {7'd1, 7'd2, 7'd3})
         begin failures++; $display("FAIL b2b fill got=%b/%h exp=111/%h", stage_valid, stage_tag, {7'd1, 7'd2, 7'd3}); end
      checks++; if (out_valid !== 1'b1 || tag_o !== 7'd1) begin failures++; $display("FAIL b2b out1 got=%b/%h exp=1/01", out_valid, tag_o); end
      snap = stage_tag;
      tag_i = 7'd4; en = 1'b0;
      @(negedge clk);
      checks++; if (stage_tag !== snap || stage_valid !== 3'b111)
         begin failures++; $display("FAIL b2b stall got=%b/%h exp=111/%h", stage_valid, stage_tag, snap); end
      clear = 3'b010;
      @(negedge clk);
      checks++; if (stage_valid !== 3'b101 || stage_tag !== {7'd1, 7'd0, 7'd3})
         begin failures++; $display("FAIL b2b clear got=%b/%h exp=101/%h", stage_valid, stage_tag, {7'd1, 7'd0, 7'd3}); end
      clear = '0; en = 1'b1;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0 || stage_valid !== 3'b011)
         begin failures++; $display("FAIL b2b bubble got=%b/%b exp=0/011", out_valid, stage_valid); end
      in_valid = 1'b0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || tag_o !== 7'd3) begin failures++; $display("FAIL b2b out3 got=%b/%h exp=1/03", out_valid, tag_o); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || tag_o !== 7'd4 || result !== 32'h40400000)
         begin failures++; $display("FAIL b2b out4 got=%b/%h/%h exp=1/04/40400000", out_valid, tag_o, result); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b drain got=%b exp=0", out_valid); end
   endtask

   task automatic test_midreset();
      @(negedge clk);
      en = 1'b1; clear = '0; in_valid = 1'b1; tag_i = 7'd9;
      @(negedge clk); tag_i = 7'd10;
      @(negedge clk);
      checks++; if (stage_valid !== 3'b011) begin failures++; $display("FAIL midrst pre got=%b exp=011", stage_valid); end
      #2 rst = 1'b0;
      #1;
      checks++; if (stage_valid !== '0 || out_valid !== 1'b0 || stage_tag !== '0 || result !== 32'h0)
         begin failures++; $display("FAIL midrst got=%b/%b/%h/%h exp=0/0/0/0", stage_valid, out_valid, stage_tag, result); end
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      repeat (4) @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst discard got=%b exp=0", out_valid); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zeros();
      test_specials();
      test_overflow();
      test_rounding();
      test_back_to_back();
      test_midreset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/fp_addsub_pipe.md
Name: fp_addsub_pipe

Overview:
- Parametrised, fully IEEE-754 floating-point add/subtract unit for the rv32imf execute stage.
- Format is generic via EXP_W/MAN_W; binary32 is the default.
- Pipeline depth is configurable.
- Supports all five RISC-V rounding modes, subnormals, fflags generation, per-stage flush, and per-stage destination-tag tracking for hazard detection.

Parameters:
- EXP_W, 8, exponent width
- MAN_W, 23, stored fraction width
- STAGES, 3, pipeline registers between input and output (legal 1..4)
- TAG_W, 7, opaque tag width: rd[4:0], reg_write, FP_reg_write

Ports:
- clk  in  1  clock
- rst  in  1  async reset, active-low
- en  in  1  advance enable (stall when low)
- clear  in  STAGES  per-stage flush; bit k kills stage k register
- in_valid  in  1  operation present at input
- op_sub  in  1  1 = a-b, 0 = a+b
- a  in  1+EXP_W+MAN_W  operand 1
- b  in  1+EXP_W+MAN_W  operand 2
- rm  in  3  000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM
- tag_i  in  TAG_W  sideband travelling with the op
- out_valid  out  1  result valid
- result  out  1+EXP_W+MAN_W  rounded result
- fflags  out  5  {NV,DZ,OF,UF,NX}
- tag_o  out  TAG_W  sideband of the result
- stage_valid  out  STAGES  valid bit of each internal stage (bit STAGES-1 = out_valid)
- stage_tag  out  STAGES*TAG_W  tag of each stage, flattened; stage k at [k*TAG_W +: TAG_W]

Behaviour:
- Reset (rst=0, async):
  - all stage valids, tags and datapath registers go to 0
  - out_valid=0, result=0, fflags=0, tag_o=0
- Datapath steps: (1) unpack/classify/align, (2) signed add, (3) normalize with leading-zero count, (4) round/pack/flags.
  - Registers sit after the last STAGES steps.
  - Merging: STAGES=3 merges 1+2; STAGES=2 merges 1+2 and 3+4; STAGES=1 is fully combinational then registered.
- Latency is exactly STAGES enabled edges. Throughput is 1 op/cycle. Outputs are registered.
- Stage register k, per edge:
  - clear[k]=1: valid and tag := 0 (datapath don't-care). Clear has priority over en.
  - else en=1: load from the upstream stage (stage 0 loads inputs; valid = in_valid).
  - else: hold.
  - Different stages may be cleared and advanced in the same cycle.
- Mid-flight reset discards all ops.
- Alignment:
  - Effective operand b' = b with sign XOR op_sub.
  - Swap so the larger magnitude is first.
  - Shift the smaller right by the exponent difference, keeping guard, round and OR-sticky. Shift amounts ≥ MAN_W+3 collapse to sticky.
  - Subnormals use exponent 1 with hidden bit 0.
- Rounding:
  - RNE: ties to even. RTZ: truncate. RDN/RUP: toward −inf/+inf. RMM: ties away from zero.
  - A mantissa carry-out from rounding increments the exponent.
  - rm 101/110/111 behaves as RNE; no trap is raised here.
- Specials:
  - Any NaN input → canonical qNaN (exp all ones, fraction MSB 1, sign 0).
  - NV=1 if either input is a signalling NaN, or for inf − inf of effective opposite signs.
  - inf ± finite → that inf; same-sign infs → that inf; no flags.
- Zeros:
  - Exact zero from opposite-sign operands → +0, except rm=RDN → −0.
  - (+0)+(+0) → +0; (−0)+(−0) → −0.
- Overflow (rounded exponent ≥ max): OF=1, NX=1.
  - Result is inf for RNE/RMM, and for RUP with positive / RDN with negative sign.
  - Otherwise the result is the largest finite number of that sign.
- UF=1 when the result is tiny after rounding AND inexact. NX=1 when any discarded bit is nonzero. DZ is always 0.
- When out_valid=0, result, fflags and tag_o hold their last values; consumers must gate on out_valid.

Test Plan:
- 0x3F800000 + 0x40000000, RNE, en=1 → result 0x40400000, fflags 0, out_valid exactly STAGES cycles after in_valid, tag_o = tag_i.
- 0x3F800000 − 0x3F800000: rm=RNE → 0x00000000; rm=RDN → 0x80000000; fflags 0.
- 0x7F800000 + 0xFF800000 → 0x7FC00000, NV; 0x7F800001 + 0x3F800000 → 0x7FC00000, NV; 0x7FC00000 + 0x3F800000 → 0x7FC00000, flags 0.
- 0x7F7FFFFF + 0x7F7FFFFF: RNE → 0x7F800000; RTZ → 0x7F7FFFFF; both OF|NX.
- 0x3F800000 + 0x30800000: RNE → 0x3F800000 NX; RUP → 0x3F800001 NX. 0x00000001 + 0x00000001 → 0x00000002, flags 0. 0x00800001 − 0x00800000 → 0x00000001, flags 0.
- Four back-to-back ops with tags 1..4:
  - en=0 for one cycle → all stages hold; stage_tag is unchanged.
  - Then clear[1] with tag 2 in stage 1 → outputs tags 1, 3, 4 only, in order; stage_valid shows the bubble.
  - rst pulse mid-stream → all valids 0 immediately.
